// File: rtl/sdp_ram_be.sv
// sdp_ram_be: simple-dual-port RAM with a shared clock.
// Features: per-lane byte-enable writes, an optional output register, a
// selectable read-during-write policy, a read-valid strobe, guarding of
// out-of-range addresses, and a sequential clear engine.
module sdp_ram_be #(
   parameter  int unsigned        WIDTH     = 16,
   parameter  int unsigned        DEPTH     = 768,
   parameter  int unsigned        BYTE_W    = 8,
   parameter  int unsigned        OUT_REG   = 0,
   parameter  int unsigned        RDW_FWD   = 1,
   parameter  logic [WIDTH-1:0]   CLR_VALUE = '0,
   localparam int unsigned        LANES     = WIDTH / BYTE_W,
   localparam int unsigned        ADDRW     = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_valid,
   input  logic [ADDRW-1:0]  i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic [LANES-1:0]  i_wr_be,
   input  logic              i_rd_req,
   input  logic [ADDRW-1:0]  i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_clr,
   output logic              o_clr_busy
);

   localparam logic [ADDRW:0]   DEPTH_L = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW-1:0] LAST    = ADDRW'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [ADDRW-1:0]  cnt_q, cnt_d;

   logic [WIDTH-1:0]  mem [DEPTH];

   logic              idle;
   logic              wr_in_range, rd_in_range;
   logic              wr_en, rd_acc, clr_we, rdw_hit;

   logic [WIDTH-1:0]  ram_q;
   logic              inr_q;
   logic [LANES-1:0]  fwd_be_q;
   logic [WIDTH-1:0]  fwd_data_q;
   logic              v1_q;
   logic [WIDTH-1:0]  s1_data;

   assign idle        = (state_q == IDLE);
   assign wr_in_range = ({1'b0, i_wr_addr} < DEPTH_L);
   assign rd_in_range = ({1'b0, i_rd_addr} < DEPTH_L);
   assign wr_en       = i_wr_valid && idle && wr_in_range;
   assign rd_acc      = i_rd_req && idle;
   assign clr_we      = (state_q == CLEAR) && !i_rst;
   assign rdw_hit     = (RDW_FWD != 0) && wr_en && (i_wr_addr == i_rd_addr);
   assign o_clr_busy  = (state_q == CLEAR);

   // Clear FSM: next state and sweep counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Clear FSM: state and counter registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory write port: the clear sweep has priority, otherwise lane-masked user write
   always_ff @(posedge i_clk) begin
      if (clr_we) begin
         mem[cnt_q] <= CLR_VALUE;
      end else if (wr_en) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if (i_wr_be[k]) begin
               mem[i_wr_addr][k*BYTE_W +: BYTE_W] <= i_wr_data[k*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Raw array read, loaded only on an accepted request so the word holds between reads
   always_ff @(posedge i_clk) begin
      if (rd_acc) begin
         ram_q <= mem[i_rd_addr];
      end
   end

   // Read side-band: range flag, forwarding lanes and first-stage valid
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         inr_q      <= 1'b0;
         fwd_be_q   <= '0;
         fwd_data_q <= '0;
         v1_q       <= 1'b0;
      end else begin
         v1_q <= rd_acc;
         if (rd_acc) begin
            inr_q      <= rd_in_range;
            fwd_be_q   <= rdw_hit ? i_wr_be : '0;
            fwd_data_q <= i_wr_data;
         end
      end
   end

   // Forwarding merge sits after the array register so the array keeps a plain read port
   always_comb begin
      s1_data = '0;
      if (inr_q) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            s1_data[k*BYTE_W +: BYTE_W] = fwd_be_q[k] ? fwd_data_q[k*BYTE_W +: BYTE_W]
                                                      : ram_q[k*BYTE_W +: BYTE_W];
         end
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      // Optional output stage: capture only when the first stage presents valid data
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
         end else begin
            o_rd_valid <= v1_q;
            if (v1_q) begin
               o_rd_data <= s1_data;
            end
         end
      end
   end else begin : g_noreg
      assign o_rd_data  = s1_data;
      assign o_rd_valid = v1_q;
   end

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb_sdp_ram_be: two sdp_ram_be instances driven with shared stimulus.
// Instance a: OUT_REG=0, RDW_FWD=1. Instance b: OUT_REG=1, RDW_FWD=0.
// Expected read words and arrival cycles are queued per instance as requests
// are issued, then matched when o_rd_valid appears.
`timescale 1ns/1ps
module tb_sdp_ram_be;

   localparam int unsigned DEPTH = 768;

   typedef struct {
      logic [15:0] data;
      int unsigned cyc;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wr_valid;
   logic [9:0]  i_wr_addr;
   logic [15:0] i_wr_data;
   logic [1:0]  i_wr_be;
   logic        i_rd_req;
   logic [9:0]  i_rd_addr;
   logic        i_clr;

   logic [15:0] a_rd_data, b_rd_data;
   logic        a_rd_valid, b_rd_valid;
   logic        a_clr_busy, b_clr_busy;

   exp_t        qa[$];
   exp_t        qb[$];
   exp_t        ma, mb;
   logic [15:0] mmem [DEPTH];
   logic        m_busy;
   int unsigned m_cnt;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   sdp_ram_be #(
      .WIDTH(16), .DEPTH(DEPTH), .BYTE_W(8), .OUT_REG(0), .RDW_FWD(1), .CLR_VALUE(16'h0000)
   ) u_dut_a (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
      .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
      .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid),
      .i_clr(i_clr), .o_clr_busy(a_clr_busy)
   );

   sdp_ram_be #(
      .WIDTH(16), .DEPTH(DEPTH), .BYTE_W(8), .OUT_REG(1), .RDW_FWD(0), .CLR_VALUE(16'h0000)
   ) u_dut_b (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
      .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
      .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid),
      .i_clr(i_clr), .o_clr_busy(b_clr_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock of stimulus; the reference model is updated as the DUT should be.
   task automatic step(input logic wv, input logic [9:0] wa, input logic [15:0] wd,
                       input logic [1:0] wbe, input logic rr, input logic [9:0] ra,
                       input logic clr);
      logic [15:0] old_w, fwd_w;
      exp_t        ea, eb;
      i_wr_valid = wv;
      i_wr_addr  = wa;
      i_wr_data  = wd;
      i_wr_be    = wbe;
      i_rd_req   = rr;
      i_rd_addr  = ra;
      i_clr      = clr;
      if (rr && !m_busy) begin
         old_w = (ra < DEPTH) ? mmem[ra] : 16'h0000;
         fwd_w = old_w;
         if (wv && (wa == ra) && (ra < DEPTH)) begin
            if (wbe[0]) fwd_w[7:0]  = wd[7:0];
            if (wbe[1]) fwd_w[15:8] = wd[15:8];
         end
         ea.data = fwd_w;
         ea.cyc  = cyc + 1;
         qa.push_back(ea);
         eb.data = old_w;
         eb.cyc  = cyc + 2;
         qb.push_back(eb);
      end
      if (m_busy) begin
         mmem[m_cnt] = 16'h0000;
         m_cnt++;
         if (m_cnt == DEPTH) m_busy = 1'b0;
      end else begin
         if (wv && (wa < DEPTH)) begin
            if (wbe[0]) mmem[wa][7:0]  = wd[7:0];
            if (wbe[1]) mmem[wa][15:8] = wd[15:8];
         end
         if (clr) begin
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end
      @(posedge i_clk);
      #1;
      check("a_busy", a_clr_busy, m_busy);
      check("b_busy", b_clr_busy, m_busy);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 10'd0, 16'h0, 2'b00, 1'b0, 10'd0, 1'b0);
   endtask

   task automatic rd(input logic [9:0] a);
      step(1'b0, 10'd0, 16'h0, 2'b00, 1'b1, a, 1'b0);
   endtask

   task automatic fill(input logic [15:0] v);
      for (int unsigned a = 0; a < DEPTH; a++) step(1'b1, 10'(a), v, 2'b11, 1'b0, 10'd0, 1'b0);
   endtask

   task automatic do_reset();
      i_rst      = 1'b1;
      i_wr_valid = 1'b0;
      i_rd_req   = 1'b0;
      i_clr      = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst  = 1'b0;
      m_busy = 1'b0;
      m_cnt  = 0;
      qa.delete();
      qb.delete();
      check("a_rst_busy",  a_clr_busy, 1'b0);
      check("b_rst_busy",  b_clr_busy, 1'b0);
      check("a_rst_valid", a_rd_valid, 1'b0);
      check("b_rst_valid", b_rd_valid, 1'b0);
      check("a_rst_data",  a_rd_data, 16'h0000);
      check("b_rst_data",  b_rd_data, 16'h0000);
   endtask

   // Scoreboard for instance a
   always @(negedge i_clk) begin
      if (a_rd_valid === 1'b1) begin
         if (qa.size() == 0) begin
            check("a_stray", a_rd_valid, 1'b0);
         end else begin
            ma = qa.pop_front();
            check("a_data", a_rd_data, ma.data);
            check("a_lat", cyc, ma.cyc);
         end
      end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
         check("a_valid", a_rd_valid, 1'b1);
         void'(qa.pop_front());
      end
   end

   // Scoreboard for instance b
   always @(negedge i_clk) begin
      if (b_rd_valid === 1'b1) begin
         if (qb.size() == 0) begin
            check("b_stray", b_rd_valid, 1'b0);
         end else begin
            mb = qb.pop_front();
            check("b_data", b_rd_data, mb.data);
            check("b_lat", cyc, mb.cyc);
         end
      end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
         check("b_valid", b_rd_valid, 1'b1);
         void'(qb.pop_front());
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst      = 1'b0;
      i_wr_valid = 1'b0;
      i_wr_addr  = '0;
      i_wr_data  = '0;
      i_wr_be    = '0;
      i_rd_req   = 1'b0;
      i_rd_addr  = '0;
      i_clr      = 1'b0;
      m_busy     = 1'b0;
      m_cnt      = 0;
      @(posedge i_clk);
      #1;
      do_reset();
      fill(16'hFFFF);

      // lane-masked writes and a be=0 no-op
      step(1'b1, 10'd5, 16'hABCD, 2'b11, 1'b0, 10'd0, 1'b0);
      step(1'b1, 10'd5, 16'h1200, 2'b10, 1'b0, 10'd0, 1'b0);
      rd(10'd5);
      step(1'b1, 10'd5, 16'h9999, 2'b00, 1'b0, 10'd0, 1'b0);
      rd(10'd5);
      idle(3);

      // back-to-back reads
      for (int unsigned i = 0; i < 4; i++) step(1'b1, 10'(i), 16'(16'h10 + i), 2'b11, 1'b0, 10'd0, 1'b0);
      for (int unsigned i = 0; i < 4; i++) rd(10'(i));
      idle(3);

      // read-during-write, same and different address
      step(1'b1, 10'd7, 16'h00FF, 2'b11, 1'b0, 10'd0, 1'b0);
      step(1'b1, 10'd7, 16'hAA55, 2'b01, 1'b1, 10'd7, 1'b0);
      rd(10'd7);
      step(1'b1, 10'd8, 16'h5A5A, 2'b11, 1'b1, 10'd7, 1'b0);
      rd(10'd8);
      idle(3);

      // address range guard
      step(1'b1, 10'd900, 16'h1234, 2'b11, 1'b0, 10'd0, 1'b0);
      step(1'b1, 10'd767, 16'hBEEF, 2'b11, 1'b0, 10'd0, 1'b0);
      rd(10'd900);
      rd(10'd132);
      rd(10'd767);
      rd(10'd768);
      idle(3);

      // full clear with user traffic in the start cycle and mid-sweep
      fill(16'hFFFF);
      step(1'b1, 10'd10, 16'h1111, 2'b11, 1'b1, 10'd5, 1'b1);
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (k == 300) step(1'b1, 10'd20, 16'h2222, 2'b11, 1'b1, 10'd20, 1'b1);
         else          idle(1);
      end
      for (int unsigned a = 0; a < DEPTH; a++) rd(10'(a));
      idle(3);

      // reset in the middle of a clear sweep
      fill(16'hFFFF);
      step(1'b0, 10'd0, 16'h0, 2'b00, 1'b0, 10'd0, 1'b1);
      idle(100);
      do_reset();
      rd(10'd0);
      rd(10'd50);
      rd(10'd99);
      rd(10'd100);
      rd(10'd101);
      rd(10'd500);
      rd(10'd767);
      idle(3);

      // reset with a read still in flight
      rd(10'd600);
      do_reset();
      idle(4);

      check("a_drain", qa.size(), 0);
      check("b_drain", qb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
